adder_hex_display: RTL and testbench
====================================

# adder_hex_display

Display stage that sits directly downstream of the 4-bit adder on the Cyclone V board. It takes the adder's 5-bit result `{cout, sum}` (0–31) and synchronizes and debounces it, since the adder inputs come from slide switches. A sequential double-dabble unit converts the stable value to two BCD digits, which drive two active-low 7-segment HEX displays. The tens digit is blanked when it is zero.

## Interface

Parameters:
- `STABLE_CYCLES`, default 50000: number of consecutive clocks the synchronized value must hold before conversion (1 ms at 50 MHz). Legal range 1 to 2^20−1.

Ports:
- `clock`  in  1  system clock, single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `sum`  in  4  adder sum, asynchronous to `clock`.
- `cout`  in  1  adder carry-out, asynchronous to `clock`.
- `hex0`  out  7  ones digit, active-low, bit order gfedcba.
- `hex1`  out  7  tens digit, active-low, blank (7'h7F) when the tens digit is 0.
- `busy`  out  1  high while a conversion is in progress (CONVERT or LATCH).
- `valid`  out  1  one-cycle pulse, concurrent with the first cycle new `hex0`/`hex1` values are visible.

## Operation

**Input path**
- `raw = {cout, sum}`, 5 bits.
- `raw` passes through a two-flop synchronizer to produce `sync2`.
- `sample` register:
  - If `sync2 != sample`: `sample <= sync2` and `stable_cnt <= 0`.
  - Otherwise `stable_cnt` increments, saturating at `STABLE_CYCLES`.
- `stable = (stable_cnt == STABLE_CYCLES)`.

**Start condition**
- The FSM leaves IDLE only when it is in IDLE, `stable` is high, and `sample != shown`.
- `shown` is the 5-bit value currently displayed.

**FSM**
- IDLE: on the start condition, load `shift = sample`, clear the BCD register (8 bits), set `iter = 0`, and go to CONVERT.
- CONVERT: one double-dabble iteration per clock.
  - Add 3 to each BCD nibble that is ≥ 5.
  - Then shift `{bcd, shift}` left by one.
  - After 5 iterations, go to LATCH.
- LATCH:
  - `shown <= converted value`.
  - `hex0 <= seg(ones)`.
  - `hex1 <= (tens == 0) ? 7'h7F : seg(tens)`.
  - Pulse `valid` in the following cycle.
  - Return to IDLE.

**Segment map (active-low)**
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (all hex).
- Tens digit is never above 3.

**Boundary behaviour**
- Input changes during CONVERT/LATCH:
  - The conversion completes with the value it captured.
  - `sample` and `stable_cnt` keep tracking the input independently.
  - After returning to IDLE, a new conversion starts once the new value is stable and differs from `shown`.
- Input bouncing shorter than `STABLE_CYCLES`: no conversion and no `valid`; the display is unchanged.
- Input returning to the displayed value after a glitch: no conversion, because `sample == shown`.

**Reset**
- Asynchronous; may be asserted at any time, including mid-conversion.
- The in-flight conversion is discarded and the FSM returns to IDLE.
- Values while reset is asserted:
  - `hex0` = 7'h40 (shows "0").
  - `hex1` = 7'h7F (blank).
  - `busy` = 0, `valid` = 0.
  - `shown` = 0, `sample` = 0, `stable_cnt` = 0, synchronizer = 0.

## Timing

- All outputs are registered; there is no combinational path from inputs to outputs.
- Conversion latency from leaving IDLE to `valid`:
  - CONVERT: 5 cycles.
  - LATCH: 1 cycle.
  - New `hex0`/`hex1` values and `valid` appear together on the 7th edge after the start condition is sampled.
- `busy` is high for exactly 6 cycles per conversion.
- End-to-end latency from a clean input change to new display values is `STABLE_CYCLES + 9` to `STABLE_CYCLES + 11` clocks. This allows for synchronizer phase.
- After LATCH, at least one IDLE cycle occurs before a new conversion starts.

## Test plan

Bench uses `STABLE_CYCLES = 4`.

1. **Reset values:** assert `reset`, then release → `hex0` = 7'h40, `hex1` = 7'h7F, `busy` = 0, `valid` = 0, and no `valid` pulse while the inputs stay at 0.
2. **Maximum value:** `cout=1`, `sum=4'hF` (31), held → within 13–15 clocks, `hex1` = 7'h30, `hex0` = 7'h79, exactly one `valid` pulse, and `busy` high for 6 cycles.
3. **Tens blanking:**
   - `cout=0`, `sum=4'h9` (9) → `hex1` = 7'h7F, `hex0` = 7'h10.
   - Then `sum=4'hA` (10) → `hex1` = 7'h79, `hex0` = 7'h40.
4. **Bounce rejection:** from a displayed value of 5, toggle `sum` between 6 and 5 every 3 clocks for 40 clocks, ending on 5 → no `valid` and `hex0` stays 7'h12.
5. **Change during conversion:**
   - Hold 17 until `busy` rises, then change to 22 during CONVERT.
   - Required: first `valid` shows 17 (`hex1` = 79, `hex0` = 78).
   - Then a second `valid` shows 22 (`hex1` = 24, `hex0` = 24).
6. **Reset mid-conversion:** assert `reset` in the 3rd CONVERT cycle of a conversion of 25 → outputs return to the reset values immediately, with no `valid`. After release with 25 still applied, the conversion reruns and shows `hex1` = 24, `hex0` = 12.

Source files
------------

// File: rtl/adder_hex_display.sv
// Display stage for the 4-bit adder: synchronizes and debounces {cout, sum},
// converts the stable value to BCD with a sequential double-dabble, and
// drives two active-low 7-segment digits (tens blanked when zero).
module adder_hex_display #(
    parameter int unsigned STABLE_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] sum,
    input  logic       cout,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic       busy,
    output logic       valid
);

    localparam logic [19:0] STABLE_MAX = 20'(STABLE_CYCLES);
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;

    state_t      state, state_nxt;
    logic [4:0]  raw, sync1, sync2, sample, shown, captured, shift;
    logic [19:0] stable_cnt;
    logic [7:0]  bcd, bcd_adj;
    logic [2:0]  iter;
    logic        stable, start;

    // Active-low segment pattern, bit order gfedcba.
    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
    endfunction

    assign raw    = {cout, sum};
    assign stable = (stable_cnt == STABLE_MAX);
    assign start  = (state == IDLE) && stable && (sample != shown);

    // Two-flop synchronizer; the switches are asynchronous to clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: restart the hold count on every change, saturate once stable.
    // Keeps tracking the input even while a conversion is running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample     <= '0;
            stable_cnt <= '0;
        end else if (sync2 != sample) begin
            sample     <= sync2;
            stable_cnt <= '0;
        end else if (!stable) begin
            stable_cnt <= stable_cnt + 20'd1;
        end
    end

    // Double-dabble correction: add 3 to any BCD nibble that is 5 or more.
    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: five CONVERT iterations, then one LATCH cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONVERT;
            CONVERT: if (iter == 3'd4) state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath and registered display outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift    <= '0;
            captured <= '0;
            bcd      <= '0;
            iter     <= '0;
            shown    <= '0;
            hex0     <= 7'h40;
            hex1     <= SEG_BLANK;
            busy     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            busy  <= (state_nxt != IDLE);
            valid <= (state == LATCH);
            case (state)
                IDLE: if (start) begin
                    shift    <= sample;
                    captured <= sample;
                    bcd      <= '0;
                    iter     <= '0;
                end
                CONVERT: begin
                    {bcd, shift} <= {bcd_adj[6:0], shift, 1'b0};
                    iter         <= iter + 3'd1;
                end
                LATCH: begin
                    shown <= captured;
                    hex0  <= seg(bcd[3:0]);
                    hex1  <= (bcd[7:4] == 4'd0) ? SEG_BLANK : seg(bcd[7:4]);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_hex_display.sv
// Directed plus randomized bench for adder_hex_display with STABLE_CYCLES = 4.
module tb_adder_hex_display;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sum   = '0;
    logic       cout  = 1'b0;
    logic [6:0] hex0, hex1;
    logic       busy, valid;

    int vectors = 0;
    int errors  = 0;
    int vcnt    = 0;
    int bcnt    = 0;

    adder_hex_display #(.STABLE_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .sum(sum), .cout(cout),
        .hex0(hex0), .hex1(hex1), .busy(busy), .valid(valid)
    );

    always #5 clock = ~clock;

    // Count valid pulses and busy cycles, sampled on the falling edge.
    always @(negedge clock) begin
        if (valid) vcnt <= vcnt + 1;
        if (busy)  bcnt <= bcnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] exp_ones(input int v);
        return segtab[v % 10];
    endfunction

    function automatic logic [6:0] exp_tens(input int v);
        return (v / 10 == 0) ? 7'h7F : segtab[v / 10];
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic apply(input int v);
        {cout, sum} = 5'(v);
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!valid && cyc < budget);
    endtask

    task automatic wait_busy(input int budget);
        int c = 0;
        while (!busy && c < budget) begin
            tick();
            c++;
        end
    endtask

    task automatic chk_display(input string tag, input int v);
        chk({tag, "_hex1"}, hex1, exp_tens(v));
        chk({tag, "_hex0"}, hex0, exp_ones(v));
    endtask

    initial begin
        int cyc, v0, b0, shown_m, v;

        // 1. Reset values and no spurious conversion with inputs at 0.
        apply(0);
        reset = 1'b1;
        tick(); tick();
        chk("rst_hex0", hex0, 7'h40);
        chk("rst_hex1", hex1, 7'h7F);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        reset = 1'b0;
        v0 = vcnt;
        repeat (20) tick();
        chk("idle_no_valid", vcnt - v0, 0);
        chk("idle_hex0", hex0, 7'h40);
        chk("idle_hex1", hex1, 7'h7F);

        // 2. Maximum value, latency, busy length, single valid.
        v0 = vcnt; b0 = bcnt;
        apply(31);
        wait_valid(30, cyc);
        chk("max_latency_ok", (cyc >= 13 && cyc <= 15), 1);
        chk_display("max", 31);
        repeat (5) tick();
        chk("max_one_valid", vcnt - v0, 1);
        chk("max_busy6", bcnt - b0, 6);
        shown_m = 31;

        // 3. Tens blanking at 9, then tens appears at 10.
        apply(9);
        wait_valid(30, cyc);
        chk("nine_valid", valid, 1);
        chk_display("nine", 9);
        apply(10);
        wait_valid(30, cyc);
        chk("ten_valid", valid, 1);
        chk_display("ten", 10);

        // 4. Bounce between 6 and 5 every 3 clocks, ending on the shown value.
        apply(5);
        wait_valid(30, cyc);
        chk_display("five", 5);
        v0 = vcnt;
        for (int i = 0; i < 14; i++) begin
            apply((i % 2 == 0) ? 6 : 5);
            repeat (3) tick();
        end
        repeat (20) tick();
        chk("bounce_no_valid", vcnt - v0, 0);
        chk("bounce_hex0", hex0, 7'h12);

        // 5. Input change during CONVERT: 17 completes, then 22 follows.
        apply(17);
        wait_busy(30);
        chk("chg_busy_rise", busy, 1);
        tick();
        apply(22);
        wait_valid(30, cyc);
        chk("chg_first_valid", valid, 1);
        chk_display("chg_first", 17);
        wait_valid(40, cyc);
        chk("chg_second_valid", valid, 1);
        chk_display("chg_second", 22);

        // 6. Reset in the 3rd CONVERT cycle of a conversion of 25.
        apply(25);
        wait_busy(30);
        chk("mid_busy_rise", busy, 1);
        tick(); tick();
        v0 = vcnt;
        reset = 1'b1;
        #1;
        chk("mid_rst_hex0", hex0, 7'h40);
        chk("mid_rst_hex1", hex1, 7'h7F);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", valid, 0);
        tick(); tick();
        reset = 1'b0;
        chk("mid_rst_no_valid", vcnt - v0, 0);
        wait_valid(30, cyc);
        chk("mid_rerun_valid", valid, 1);
        chk_display("mid_rerun", 25);
        shown_m = 25;

        // Randomized held values against the arithmetic digit model.
        for (int k = 0; k < 16; k++) begin
            v = $urandom_range(0, 31);
            v0 = vcnt; b0 = bcnt;
            apply(v);
            if (v == shown_m) begin
                repeat (20) tick();
                chk("rnd_same_no_valid", vcnt - v0, 0);
            end else begin
                wait_valid(30, cyc);
                chk("rnd_latency_ok", (cyc >= 13 && cyc <= 15), 1);
                repeat (3) tick();
                chk("rnd_busy6", bcnt - b0, 6);
                chk("rnd_one_valid", vcnt - v0, 1);
            end
            chk_display("rnd", v);
            shown_m = v;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
